// File: rtl/result_display_pkg.sv
// Shared 7-segment definitions: segment bit positions, glyph constants and the
// capture/digit types used by the result display and later display blocks.
package result_display_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] GLYPH_1    = 7'b0000110;
   localparam logic [6:0] GLYPH_2    = 7'b1011011;
   localparam logic [6:0] GLYPH_3    = 7'b1001111;
   localparam logic [6:0] GLYPH_4    = 7'b1100110;
   localparam logic [6:0] GLYPH_5    = 7'b1101101;
   localparam logic [6:0] GLYPH_6    = 7'b1111101;
   localparam logic [6:0] GLYPH_DASH = 7'b1000000;
   localparam logic [6:0] GLYPH_D    = 7'b1011110;
   localparam logic [6:0] GLYPH_T    = 7'b1111000;

   typedef enum logic {
      DIGIT_VALUE = 1'b0,
      DIGIT_MODE  = 1'b1
   } digit_e;

   typedef struct packed {
      logic       mode;
      logic [2:0] val;
   } cap_t;

   // Traffic lamps map to horizontal bars: red on top, amber in the middle, green at the bottom.
   function automatic logic [6:0] traffic_glyph(input logic [2:0] rag);
      logic [6:0] g;
      g        = 7'b0000000;
      g[SEG_A] = rag[2];
      g[SEG_G] = rag[1];
      g[SEG_D] = rag[0];
      return g;
   endfunction

endpackage

// File: rtl/result_display_seg_glyph.sv
// Combinational decoder from the selected digit and captured {mode,val}
// to the segment pattern {g,f,e,d,c,b,a}.
module seg_glyph
   import result_display_pkg::*;
(
   input  digit_e     digit,
   input  cap_t       value,
   output logic [6:0] seg
);

   always_comb begin
      seg = GLYPH_DASH;
      if (digit == DIGIT_MODE) begin
         seg = value.mode ? GLYPH_T : GLYPH_D;
      end else if (value.mode) begin
         seg = traffic_glyph(value.val);
      end else begin
         case (value.val)
            3'd1:    seg = GLYPH_1;
            3'd2:    seg = GLYPH_2;
            3'd3:    seg = GLYPH_3;
            3'd4:    seg = GLYPH_4;
            3'd5:    seg = GLYPH_5;
            3'd6:    seg = GLYPH_6;
            default: seg = GLYPH_DASH;
         endcase
      end
   end

endmodule

// File: rtl/result_display.sv
// Captures the dice/traffic mux output, drives a two-digit multiplexed
// 7-segment display and flags/counts changes of the captured value.
module result_display
   import result_display_pkg::*;
#(
   parameter int SCAN_DIV = 4,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic [2:0]       result,
   input  logic             freeze,
   output logic [6:0]       seg,
   output logic [1:0]       an,
   output logic             changed,
   output logic [CNT_W-1:0] change_count
);

   localparam int            CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

   cap_t          cap;
   cap_t          cap_in;
   logic          valid;
   logic          pending;
   logic [CW-1:0] scan_cnt;
   digit_e        digit;
   digit_e        digit_next;
   logic [6:0]    glyph;

   assign cap_in = cap_t'({sel, result});

   // Capture register; the comparison result is held one cycle so the pulse follows the load.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap     <= cap_t'(4'b0000);
         valid   <= 1'b0;
         pending <= 1'b0;
      end else if (!freeze) begin
         cap     <= cap_in;
         valid   <= 1'b1;
         pending <= valid && (cap_in != cap);
      end else begin
         cap     <= cap;
         valid   <= valid;
         pending <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         changed      <= 1'b0;
         change_count <= '0;
      end else begin
         changed <= pending;
         if (pending && (change_count != {CNT_W{1'b1}})) begin
            change_count <= change_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            change_count <= change_count;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         digit    <= DIGIT_VALUE;
      end else begin
         scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + {{(CW-1){1'b0}}, 1'b1};
         digit    <= digit_next;
      end
   end

   always_comb begin
      digit_next = digit;
      if (scan_cnt == SCAN_LAST) begin
         case (digit)
            DIGIT_VALUE: digit_next = DIGIT_MODE;
            DIGIT_MODE:  digit_next = DIGIT_VALUE;
            default:     digit_next = DIGIT_VALUE;
         endcase
      end else begin
         digit_next = digit;
      end
   end

   seg_glyph u_glyph (
      .digit (digit),
      .value (cap),
      .seg   (glyph)
   );

   // seg and an share one edge so a glyph never lands on the wrong digit.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= 7'b0000000;
         an  <= 2'b00;
      end else begin
         seg <= glyph;
         an  <= (digit == DIGIT_VALUE) ? 2'b01 : 2'b10;
      end
   end

endmodule
